// File: rtl/attn_score_pkg.sv
// Shared types for the attention-score drain path: FSM states, the beat that
// travels through the output skid buffer, and the default matrix geometry.
package attn_score_pkg;

  localparam int SKID_DEPTH = 2;

  // Geometry carried by score_beat_t; the drain controller defaults to these.
  localparam int SCORE_M      = 8;
  localparam int SCORE_N      = 8;
  localparam int SCORE_DATA_W = 32;
  localparam int SCORE_ROW_W  = (SCORE_M <= 1) ? 1 : $clog2(SCORE_M);
  localparam int SCORE_COL_W  = (SCORE_N <= 1) ? 1 : $clog2(SCORE_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_e;

  typedef struct packed {
    logic [SCORE_DATA_W-1:0] data;
    logic [SCORE_ROW_W-1:0]  row;
    logic [SCORE_COL_W-1:0]  col;
    logic                    last;
    logic                    row_last;
  } score_beat_t;

  // Entries that will occupy the skid buffer once every outstanding read lands,
  // after this cycle's pop. A pop implies occ >= 1, so this never underflows.
  function automatic logic [1:0] window_fill(input logic [1:0] occ,
                                             input logic       inflight,
                                             input logic       pop);
    return occ + {1'b0, inflight} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/attn_skid_fifo2.sv
// Two-entry skid FIFO of score beats; push and pop may happen in the same
// cycle, and clear empties it without touching the stored payload.
module attn_skid_fifo2
  import attn_score_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  score_beat_t push_beat,
  input  logic        pop,
  output logic [1:0]  occ,
  output score_beat_t head
);

  score_beat_t mem_reg [SKID_DEPTH];
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  occ_reg;
  logic        do_push;
  logic        do_pop;

  assign do_pop  = pop && (occ_reg != 2'd0);
  assign do_push = push && ((occ_reg != 2'(SKID_DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else if (clear) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_beat;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      occ_reg <= occ_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign occ  = occ_reg;
  assign head = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/attn_score_drain_ctrl.sv
// Drains the M x N score matrix from SRAM read port A in row-major order and
// streams it out through a 2-entry skid buffer with valid/ready handshaking.
module attn_score_drain_ctrl
  import attn_score_pkg::*;
#(
  parameter int M      = SCORE_M,
  parameter int N      = SCORE_N,
  parameter int DATA_W = SCORE_DATA_W,
  parameter int ROW_W  = (M <= 1) ? 1 : $clog2(M),
  parameter int COL_W  = (N <= 1) ? 1 : $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              c_en,
  output logic              c_re,
  output logic [ROW_W-1:0]  c_row,
  output logic [COL_W-1:0]  c_col,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_rvalid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              out_last,
  output logic              out_row_last
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N - 1);

  drain_state_e     state_reg, state_next;
  logic [ROW_W-1:0] rd_row_reg, rd_row_next;
  logic [COL_W-1:0] rd_col_reg, rd_col_next;
  logic             inflight_reg, inflight_next;
  logic [ROW_W-1:0] tag_row_reg;
  logic [COL_W-1:0] tag_col_reg;
  logic             tag_last_reg;
  logic             tag_row_last_reg;

  logic             issue;
  logic             pop;
  logic             push;
  logic             at_last_addr;
  logic [1:0]       fifo_occ;
  score_beat_t      push_beat;
  score_beat_t      head;

  assign out_valid    = (fifo_occ != 2'd0);
  assign pop          = out_valid && out_ready;
  assign at_last_addr = (rd_row_reg == LAST_ROW) && (rd_col_reg == LAST_COL);

  // Issue only if the read can still land in the skid buffer; depends on
  // out_ready combinationally so a draining consumer sees one beat per cycle.
  assign issue = (state_reg == RUN) && !abort &&
                 (window_fill(fifo_occ, inflight_reg, pop) < 2'(SKID_DEPTH));

  // Returns for a read that abort or reset already discarded are dropped.
  assign push = c_rvalid && inflight_reg && !abort;

  always_comb begin
    push_beat          = '0;
    push_beat.data     = SCORE_DATA_W'(c_rdata);
    push_beat.row      = SCORE_ROW_W'(tag_row_reg);
    push_beat.col      = SCORE_COL_W'(tag_col_reg);
    push_beat.last     = tag_last_reg;
    push_beat.row_last = tag_row_last_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      rd_row_reg       <= '0;
      rd_col_reg       <= '0;
      inflight_reg     <= 1'b0;
      tag_row_reg      <= '0;
      tag_col_reg      <= '0;
      tag_last_reg     <= 1'b0;
      tag_row_last_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_row_reg   <= rd_row_next;
      rd_col_reg   <= rd_col_next;
      inflight_reg <= inflight_next;
      if (issue) begin
        tag_row_reg      <= rd_row_reg;
        tag_col_reg      <= rd_col_reg;
        tag_last_reg     <= at_last_addr;
        tag_row_last_reg <= (rd_col_reg == LAST_COL);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (issue && at_last_addr) state_next = FLUSH;
        FLUSH:   if (!inflight_reg && (fifo_occ == 2'd0)) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Address walk: column wraps into the next row; the final address holds.
  always_comb begin
    rd_row_next = rd_row_reg;
    rd_col_next = rd_col_reg;
    if (abort || ((state_reg == IDLE) && start)) begin
      rd_row_next = '0;
      rd_col_next = '0;
    end else if (issue && !at_last_addr) begin
      if (rd_col_reg == LAST_COL) begin
        rd_col_next = '0;
        rd_row_next = rd_row_reg + 1'b1;
      end else begin
        rd_col_next = rd_col_reg + 1'b1;
      end
    end
  end

  always_comb begin
    inflight_next = inflight_reg;
    if (abort) begin
      inflight_next = 1'b0;
    end else if (issue) begin
      inflight_next = 1'b1;
    end else if (c_rvalid) begin
      inflight_next = 1'b0;
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      RUN, FLUSH: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  assign c_en  = issue;
  assign c_re  = issue;
  assign c_row = rd_row_reg;
  assign c_col = rd_col_reg;

  attn_skid_fifo2 u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (abort),
    .push      (push),
    .push_beat (push_beat),
    .pop       (pop),
    .occ       (fifo_occ),
    .head      (head)
  );

  assign out_data     = DATA_W'(head.data);
  assign out_row      = ROW_W'(head.row);
  assign out_col      = COL_W'(head.col);
  assign out_last     = out_valid && head.last;
  assign out_row_last = out_valid && head.row_last;

endmodule
